// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NREGS_D = 16;
  localparam int AW_D    = 4;
  localparam int DW_D    = 32;

endpackage

// File: rtl/regdump_pair_buf.sv
// Two-entry capture buffer: holds one register pair and presents w0 then w1.
// Output fields come straight from registers, so they stay stable while stalled.
module regdump_pair_buf
  import regdump_pkg::*;
#(
  parameter int AW = AW_D,
  parameter int DW = DW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          pop,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW-1:0] addr,
  output logic [1:0]    occ
);

  logic [DW-1:0] w0, w1;
  logic [AW-1:0] wa0, wa1;

  // occ counts words still to send: 2 -> w0 is next, 1 -> w1 is next
  always_ff @(posedge clk) begin
    if (rst) begin
      w0  <= '0;
      w1  <= '0;
      wa0 <= '0;
      wa1 <= '0;
      occ <= 2'd0;
    end else if (load) begin
      w0  <= d0;
      w1  <= d1;
      wa0 <= a0;
      wa1 <= a1;
      occ <= 2'd2;
    end else if (pop && occ != 2'd0) begin
      occ <= occ - 2'd1;
    end
  end

  assign valid = (occ != 2'd0);

  always_comb begin
    data = '0;
    addr = '0;
    if (occ == 2'd2) begin
      data = w0;
      addr = wa0;
    end else if (occ == 2'd1) begin
      data = w1;
      addr = wa1;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register file two registers per fetch and streams the values out.
// Optional REGDUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  parameter int AW    = AW_D,
  parameter int DW    = DW_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] A1,
  output logic [AW-1:0] A2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last
);

  localparam int NPAIRS = NREGS / 2;
  localparam int PW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  state_e        state, state_nx;
  logic [PW-1:0] pidx;
  logic          capture, last_pair, final_hs;
  logic          buf_valid, buf_pop;
  logic [DW-1:0] buf_data;
  logic [AW-1:0] buf_addr;
  logic [1:0]    buf_occ;

  assign last_pair = (pidx == PW'(NPAIRS - 1));
  assign buf_pop   = buf_valid && out_ready;

  // Refill as soon as the buffer is empty, or back-to-back when w1 leaves
  assign capture = (state == READ) &&
                   ((buf_occ == 2'd0) || (buf_occ == 2'd1 && buf_pop));

  assign A1 = (state == READ) ? AW'({pidx, 1'b0}) : '0;
  assign A2 = (state == READ) ? AW'({pidx, 1'b1}) : '0;

  regdump_pair_buf #(
    .AW(AW),
    .DW(DW)
  ) u_pair_buf (
    .clk  (clk),
    .rst  (rst),
    .load (capture),
    .pop  (buf_pop),
    .d0   (RD1),
    .d1   (RD2),
    .a0   (A1),
    .a1   (A2),
    .valid(buf_valid),
    .data (buf_data),
    .addr (buf_addr),
    .occ  (buf_occ)
  );

`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] csum;
  logic          csum_pend, csum_show;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum      <= '0;
      csum_pend <= 1'b0;
    end else if (state == IDLE && start) begin
      csum      <= '0;
      csum_pend <= 1'b0;
    end else begin
      if (capture) csum <= csum ^ RD1 ^ RD2;
      if (capture && last_pair) csum_pend <= 1'b1;
      else if (csum_show && out_ready) csum_pend <= 1'b0;
    end
  end

  // Checksum goes out only once the final pair has fully drained
  assign csum_show = (state == DRAIN) && !buf_valid && csum_pend;
  assign out_valid = buf_valid || csum_show;
  assign out_data  = buf_valid ? buf_data : (csum_show ? csum : '0);
  assign out_addr  = buf_valid ? buf_addr : '0;
  assign out_last  = csum_show;
  assign final_hs  = csum_show && out_ready;
`else
  assign out_valid = buf_valid;
  assign out_data  = buf_data;
  assign out_addr  = buf_addr;
  assign out_last  = buf_valid && (buf_addr == AW'(NREGS - 1));
  assign final_hs  = out_last && out_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pidx  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) pidx <= '0;
      else if (capture)  pidx <= pidx + PW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (capture && last_pair) state_nx = DRAIN;
      DRAIN:   if (final_hs) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == READ) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats queued per dump,
// a negedge monitor pops and compares on every output handshake.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk, rst, start, busy, done;
  logic [3:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_addr;

  logic        we3;
  logic [3:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rf [16];
  logic [31:0] exp_rf [16];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int beat_cnt, first_cyc, last_cyc;

  beat_t sb_q[$];
  bit          exp_done, stall_prev;
  logic [31:0] hold_data;
  logic [3:0]  hold_addr;
  logic        hold_last;

  regfile_dump_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .A1       (A1),
    .A2       (A2),
    .RD1      (RD1),
    .RD2      (RD2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: combinational reads, clocked WE3 writes
  always @(posedge clk) if (we3) rf[a3] <= wd3;
  assign RD1 = rf[A1];
  assign RD2 = rf[A2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_prev = 0;
      exp_done   = 0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        exp_done = 0;
      end else if (done) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end
      if (stall_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", out_data, hold_data);
        chk("hold_addr", {28'd0, out_addr}, {28'd0, hold_addr});
        chk("hold_last", {31'd0, out_last}, {31'd0, hold_last});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat_addr", {28'd0, out_addr}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("beat_addr", {28'd0, out_addr}, {28'd0, e.addr});
          chk("beat_data", out_data, e.data);
          chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
        end
        if (beat_cnt == 0) first_cyc = cyc;
        beat_cnt++;
        if (out_last) begin
          exp_done = 1;
          last_cyc = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
      hold_addr  = out_addr;
      hold_last  = out_last;
    end
  end

  // kind 0: test-plan pattern, 1: random, 2: zeros with reg3=0xFF
  task automatic preload(input int kind);
    logic [31:0] v;
    for (int r = 0; r < 16; r++) begin
      case (kind)
        0:       v = (r == 15) ? 32'hABCD_EF01 : 32'h1000_0000 + 32'(r);
        1:       v = $urandom;
        default: v = (r == 3) ? 32'h0000_00FF : 32'd0;
      endcase
      @(posedge clk); #1;
      we3 = 1; a3 = r[3:0]; wd3 = v;
      exp_rf[r] = v;
    end
    @(posedge clk); #1;
    we3 = 0;
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready
  task automatic run_dump(input int mode, input bit wr_en, input int wr_off,
                          input int wr_a, input logic [31:0] wr_d,
                          input bit extra_start, input bit chk_timing);
    logic [31:0] x, v;
    beat_t b;
    bit seen_done;
    int start_cyc, done_cyc;
    x = 0;
    seen_done = 0;
    done_cyc = 0;
    // Pair p is read in relative cycle 1+2p at full ready; a write landing
    // at the end of an earlier cycle is part of the snapshot
    for (int r = 0; r < 16; r++) begin
      v = exp_rf[r];
      if (wr_en && r == wr_a && wr_off < 1 + 2 * (r / 2)) v = wr_d;
      x ^= v;
      b.addr = r[3:0];
      b.data = v;
      b.last = (r == 15) && (CSUM == 0);
      sb_q.push_back(b);
    end
    if (CSUM != 0) begin
      b.addr = 4'd0;
      b.data = x;
      b.last = 1'b1;
      sb_q.push_back(b);
    end
    if (wr_en) exp_rf[wr_a] = wr_d;
    beat_cnt = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      start = (i == 0) || (extra_start && (i == 5 || i == 9));
      we3   = wr_en && (i == wr_off);
      a3    = wr_a[3:0];
      wd3   = wr_d;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (i % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end
    end
    start = 0;
    we3 = 0;
    out_ready = 1;
    chk("dump_completed", {31'd0, seen_done}, 32'd1);
    chk("beat_count", beat_cnt, 16 + CSUM);
    chk("queue_drained", sb_q.size(), 0);
    if (chk_timing) begin
      chk("lat_first_beat", first_cyc - start_cyc, 2);
      chk("lat_last_beat", last_cyc - start_cyc, 17 + CSUM);
      chk("lat_done", done_cyc - start_cyc, 18 + CSUM);
    end
    sb_q.delete();
    @(posedge clk); #1;
    chk("idle_after_done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_mid_dump();
    bit found;
    beat_t b;
    found = 0;
    for (int r = 0; r < 16; r++) begin
      b.addr = r[3:0];
      b.data = exp_rf[r];
      b.last = (r == 15) && (CSUM == 0);
      sb_q.push_back(b);
    end
    beat_cnt = 0;
    out_ready = 1;
    @(posedge clk); #1;
    start = 1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      start = 0;
      if (out_valid && out_addr == 4'd6) found = 1;
    end
    chk("reached_reg6", {31'd0, found}, 32'd1);
    rst = 1;
    sb_q.delete();
    @(posedge clk); #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_done", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst = 1; start = 0; out_ready = 1; we3 = 0; a3 = 0; wd3 = 0;
    exp_done = 0; stall_prev = 0; beat_cnt = 0; first_cyc = 0; last_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_A1", {28'd0, A1}, 32'd0);
    chk("rst_A2", {28'd0, A2}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", {28'd0, out_addr}, 32'd0);
    rst = 0;

    preload(0);
    run_dump(0, 0, 0, 0, 32'd0, 0, 1);
    run_dump(1, 0, 0, 0, 32'd0, 0, 0);

    run_dump(0, 1, 4, 4, 32'h1234_5678, 0, 1);
    preload(0);
    run_dump(0, 1, 5, 4, 32'h1234_5678, 0, 1);
    preload(0);

    reset_mid_dump();
    run_dump(0, 0, 0, 0, 32'd0, 0, 1);

    run_dump(0, 0, 0, 0, 32'd0, 1, 1);

    for (int k = 0; k < 4; k++) begin
      preload(1);
      run_dump(2, 0, 0, 0, 32'd0, 1'($urandom_range(0, 1)), 0);
    end

    preload(2);
    run_dump(0, 0, 0, 0, 32'd0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Read-side sequencer for the 16×32 ARM-style `RegisterFile`. On a start pulse it walks every architectural register through the two combinational read ports, A1/RD1 and A2/RD2, two registers per fetch. It then streams each value out, one word per beat, on a valid/ready interface. It sits beside the datapath and feeds the debug/trace path; writes through A3/WD3/WE3 stay with the core.

## Interface
Parameters:
- NREGS, 16: registers dumped; must be even, at most 2^AW.
- AW, 4: register address width.
- DW, 32: data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- busy  out  1  high from the first READ cycle through the last output handshake.
- done  out  1  one-cycle pulse on the cycle after the final handshake.
- A1  out  AW  register file read address 1; always an even index.
- A2  out  AW  register file read address 2; always A1+1.
- RD1  in  DW  register file read data 1; combinational from A1.
- RD2  in  DW  register file read data 2; combinational from A2.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DW  register value, or the checksum word.
- out_addr  out  AW  register index of out_data; 0 for the checksum word.
- out_last  out  1  marks the final word of the dump.

## Operation
- States:
  - IDLE → READ when start=1.
  - READ → DRAIN on the capture of the last pair.
  - DRAIN → DONE on the final handshake.
  - DONE → IDLE unconditionally after one cycle.
- The pair counter pidx runs 0..NREGS/2-1. A1 is driven as 2·pidx and A2 as 2·pidx+1 in READ. Both addresses are 0 in other states.
- The pair buffer holds two words (w0, w1) plus their addresses and a 2-bit occupancy.
- Capture:
  - Condition: in READ, when the buffer is empty, or when w1 handshakes in the same cycle.
  - Action: RD1→w0, RD2→w1, then pidx++.
- Output order: w0, then w1, one handshake each (out_valid & out_ready).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_addr and out_last hold stable.
- The dump is a per-pair snapshot. A concurrent WE3 write is reflected only if it lands before that pair's capture edge.
- start during busy is ignored. There is no abort input.
- out_last is set on register NREGS-1 when REGDUMP_CHECKSUM_EN is undefined.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, out_valid=0, out_last=0.
  - A1=0, A2=0, out_data=0, out_addr=0.
  - Buffer empty, pidx=0.
- Latency with start at cycle 0 and out_ready held 1:
  - Cycle 1: READ, A1=0/A2=1, capture.
  - Cycle 2: reg0 output.
  - Cycle 3: reg1 output, with pair 1 captured that same cycle.
  - Cycle 17: reg15 output.
  - Cycle 18: done. With the checksum, the checksum is output at cycle 18 and done comes at cycle 19.
- Throughput is one word per cycle with no bubbles at full ready.
- A reset asserted mid-dump forces IDLE on the next edge, drops out_valid, and discards the buffer and pidx. No done is produced.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - After register NREGS-1, one extra word is emitted: the XOR of all dumped values, with out_addr=0 and out_last=1.
  - The checksum accumulator clears on start.
- REGDUMP_CHECKSUM_EN undefined: no extra word, and no accumulator logic.

## Structure
- regdump_pkg holds:
  - The state enum: IDLE, READ, DRAIN, DONE.
  - The default constants NREGS_D=16, AW_D=4, DW_D=32.
- Sub-module regdump_pair_buf: the two-entry capture buffer, with load, pop, occupancy and the stable-hold logic. The FSM and pidx stay in the top.

## Test plan
- Preload regs i=0..14 with 0x1000_0000+i and drive R15=0xABCDEF01. Pulse start with out_ready=1 → 16 words in order, reg0 at cycle 2, out_last with out_addr=15 and data 0xABCDEF01 at cycle 17, done at cycle 18.
- Same preload, with out_ready toggling 1/0 each cycle → identical sequence, data held during stalls, no word lost or duplicated.
- Write 0x12345678 to reg 4 via WE3 one cycle before pair 2's capture → reg4 reported as 0x12345678. The same write after the capture → the old value is reported.
- Assert rst at the reg6 beat → next cycle out_valid=0 and busy=0, no done. A fresh start then dumps from reg0.
- Pulse start while busy → ignored, exactly 16 (or 17) beats.
- With REGDUMP_CHECKSUM_EN: all regs=0 except reg3=0xFF → 17th word 0x000000FF with out_addr=0 and out_last=1, done at cycle 19.
